// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a qualified stable
// lock with timeout and bounded retries, then releases the downstream system reset.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17,
    parameter int LOSS_W        = 8
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              relock_req,
    output logic              pll_rst,
    output logic              sys_reset,
    output logic              ready,
    output logic              fail,
    output logic [LOSS_W-1:0] lock_loss_count,
    output logic [2:0]        state_dbg
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_SAT     = {LOSS_W{1'b1}};

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   timer, next_timer;
    logic [RETRY_W-1:0] retry, next_retry;
    logic [LOSS_W-1:0]  next_loss;
    logic               sync_meta, sync_mid, locked_s;

    // Synchronizer chain: locked_s presents a sample two edges after it was taken.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_mid  <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            sync_mid  <= sync_meta;
            locked_s  <= sync_mid;
        end
    end

    always_comb begin
        next_state = state;
        next_timer = timer;
        next_retry = retry;
        next_loss  = lock_loss_count;
        if (relock_req) begin
            next_state = S_RESET_PLL;
            next_timer = '0;
            next_retry = '0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (timer == RST_LAST) begin
                        next_state = S_WAIT_LOCK;
                        next_timer = '0;
                    end else begin
                        next_timer = timer + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = S_STABLE;
                        next_timer = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        next_timer = '0;
                        if (retry == RETRY_LIMIT) begin
                            next_state = S_FAIL;
                        end else begin
                            next_state = S_RESET_PLL;
                            next_retry = retry + RETRY_W'(1);
                        end
                    end else begin
                        next_timer = timer + CNT_W'(1);
                    end
                end
                // A lock drop during qualification re-waits without spending a retry.
                S_STABLE: begin
                    if (!locked_s) begin
                        next_state = S_WAIT_LOCK;
                        next_timer = '0;
                    end else if (timer == STABLE_LAST) begin
                        next_state = S_RUN;
                        next_timer = '0;
                        next_retry = '0;
                    end else begin
                        next_timer = timer + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        next_state = S_RESET_PLL;
                        next_timer = '0;
                        if (lock_loss_count != LOSS_SAT) begin
                            next_loss = lock_loss_count + LOSS_W'(1);
                        end
                    end
                end
                S_FAIL: begin
                    next_state = S_FAIL;
                end
                default: begin
                    next_state = S_RESET_PLL;
                    next_timer = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next_state so they switch on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state           <= S_RESET_PLL;
            timer           <= '0;
            retry           <= '0;
            lock_loss_count <= '0;
            pll_rst         <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            fail            <= 1'b0;
            state_dbg       <= 3'd0;
        end else begin
            state           <= next_state;
            timer           <= next_timer;
            retry           <= next_retry;
            lock_loss_count <= next_loss;
            pll_rst         <= (next_state == S_RESET_PLL) || (next_state == S_FAIL);
            sys_reset       <= (next_state != S_RUN);
            ready           <= (next_state == S_RUN);
            fail            <= (next_state == S_FAIL);
            state_dbg       <= next_state;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with targeted
// timing checks plus randomized lock/relock activity against a behavioural model.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 17;
    localparam int LOSS_W        = 8;

    logic              refclk = 1'b0;
    logic              rst = 1'b0;
    logic              pll_locked = 1'b0;
    logic              relock_req = 1'b0;
    logic              pll_rst, sys_reset, ready, fail;
    logic [LOSS_W-1:0] lock_loss_count;
    logic [2:0]        state_dbg;

    int passed = 0;
    int total  = 0;

    // Behavioural model: phase 0..4 = hold, await lock, qualify, run, failed.
    int m_phase, m_elapsed, m_retries, m_losses;
    bit lock_hist[$];

    always #10 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W), .LOSS_W(LOSS_W)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
        .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .fail(fail),
        .lock_loss_count(lock_loss_count), .state_dbg(state_dbg)
    );

    function automatic void model_reset();
        m_phase = 0; m_elapsed = 0; m_retries = 0; m_losses = 0;
        lock_hist.delete();
        repeat (3) lock_hist.push_back(1'b0);
    endfunction

    function automatic void model_edge(bit lk, bit rq);
        bit seen;
        seen = lock_hist.pop_front();
        lock_hist.push_back(lk);
        if (rq) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0;
        end else if (m_phase == 0) begin
            if (m_elapsed == RST_CYCLES - 1) begin m_phase = 1; m_elapsed = 0; end
            else m_elapsed++;
        end else if (m_phase == 1) begin
            if (seen) begin m_phase = 2; m_elapsed = 0; end
            else if (m_elapsed == LOCK_TIMEOUT - 1) begin
                m_elapsed = 0;
                if (m_retries == MAX_RETRIES) m_phase = 4;
                else begin m_retries++; m_phase = 0; end
            end else m_elapsed++;
        end else if (m_phase == 2) begin
            if (!seen) begin m_phase = 1; m_elapsed = 0; end
            else if (m_elapsed == STABLE_CYCLES - 1) begin m_phase = 3; m_elapsed = 0; m_retries = 0; end
            else m_elapsed++;
        end else if (m_phase == 3) begin
            if (!seen) begin
                m_phase = 0; m_elapsed = 0;
                m_losses = (m_losses < 255) ? m_losses + 1 : 255;
            end
        end
    endfunction

    function automatic logic [14:0] model_outputs();
        return {(m_phase == 0 || m_phase == 4), (m_phase != 3), (m_phase == 3),
                (m_phase == 4), 3'(m_phase), 8'(m_losses)};
    endfunction

    task automatic tick();
        @(posedge refclk);
        if (rst) model_reset();
        else model_edge(pll_locked, relock_req);
        @(negedge refclk);
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] got;
        #3 rst = 1'b1;
        #1 got = {pll_rst, sys_reset, ready, fail, state_dbg, lock_loss_count};
        if (got !== 15'h6000) $display("[TB] FAIL reset_values: got %h expected %h", got, 15'h6000);
        else passed++;
        total++;
        model_reset();
        repeat (3) tick();
        got = {pll_rst, sys_reset, ready, fail, state_dbg, lock_loss_count};
        if (got !== 15'h6000) $display("[TB] FAIL reset_held: got %h expected %h", got, 15'h6000);
        else passed++;
        total++;
        rst = 1'b0;
    endtask

    task automatic test_lock_sequence();
        int cnt;
        do_reset();
        cnt = 0;
        do begin tick(); cnt++; end while (pll_rst && cnt < 50);
        if (cnt !== RST_CYCLES) $display("[TB] FAIL pll_rst_width: got %0d expected %0d", cnt, RST_CYCLES);
        else passed++;
        total++;
        repeat (5) tick();
        pll_locked = 1'b1;
        tick();
        cnt = 0;
        while (!ready && cnt < 100) begin tick(); cnt++; end
        if (cnt !== 3 + STABLE_CYCLES) $display("[TB] FAIL lock_to_ready: got %0d expected %0d", cnt, 3 + STABLE_CYCLES);
        else passed++;
        total++;
        if ({sys_reset, pll_rst, state_dbg} !== 5'b00011)
            $display("[TB] FAIL run_outputs: got %b expected %b", {sys_reset, pll_rst, state_dbg}, 5'b00011);
        else passed++;
        total++;
    endtask

    task automatic test_fail_retry();
        int cnt, high, low;
        do_reset();
        cnt = 0; high = 0; low = 0;
        while (!fail && cnt < 200) begin
            if (pll_rst) high++; else low++;
            tick();
            cnt++;
        end
        if (cnt !== 3 * (RST_CYCLES + LOCK_TIMEOUT)) $display("[TB] FAIL time_to_fail: got %0d expected %0d", cnt, 3 * (RST_CYCLES + LOCK_TIMEOUT));
        else passed++;
        total++;
        if (high !== 3 * RST_CYCLES || low !== 3 * LOCK_TIMEOUT)
            $display("[TB] FAIL pulse_pattern: got high=%0d low=%0d expected high=%0d low=%0d", high, low, 3 * RST_CYCLES, 3 * LOCK_TIMEOUT);
        else passed++;
        total++;
        repeat (5) tick();
        if ({fail, pll_rst, sys_reset, state_dbg} !== 6'b111100)
            $display("[TB] FAIL fail_state: got %b expected %b", {fail, pll_rst, sys_reset, state_dbg}, 6'b111100);
        else passed++;
        total++;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        if ({fail, pll_rst, state_dbg} !== 5'b01000)
            $display("[TB] FAIL relock_exit: got %b expected %b", {fail, pll_rst, state_dbg}, 5'b01000);
        else passed++;
        total++;
        cnt = 0;
        while (pll_rst && cnt < 50) begin tick(); cnt++; end
        if (cnt !== RST_CYCLES) $display("[TB] FAIL relock_hold: got %0d expected %0d", cnt, RST_CYCLES);
        else passed++;
        total++;
    endtask

    task automatic test_stable_glitch();
        int cnt;
        bit saw_wait;
        do_reset();
        pll_locked = 1'b1;
        cnt = 0;
        while (!(m_phase == 2 && m_elapsed == 3) && cnt < 100) begin tick(); cnt++; end
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        tick();
        cnt = 0; saw_wait = 1'b0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
            if (state_dbg == 3'd1) saw_wait = 1'b1;
        end
        if (saw_wait !== 1'b1) $display("[TB] FAIL glitch_requalify: got %0d expected %0d", saw_wait, 1);
        else passed++;
        total++;
        if (cnt !== 3 + STABLE_CYCLES) $display("[TB] FAIL glitch_to_ready: got %0d expected %0d", cnt, 3 + STABLE_CYCLES);
        else passed++;
        total++;
    endtask

    task automatic test_run_loss();
        int cnt;
        do_reset();
        pll_locked = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin tick(); cnt++; end
        pll_locked = 1'b0;
        tick();
        cnt = 0;
        while (!sys_reset && cnt < 20) begin tick(); cnt++; end
        if (cnt !== 3) $display("[TB] FAIL loss_latency: got %0d expected %0d", cnt, 3);
        else passed++;
        total++;
        if ({ready, pll_rst, lock_loss_count} !== {1'b0, 1'b1, 8'd1})
            $display("[TB] FAIL loss_outputs: got %b expected %b", {ready, pll_rst, lock_loss_count}, {1'b0, 1'b1, 8'd1});
        else passed++;
        total++;
        for (int n = 2; n <= 300; n++) begin
            pll_locked = 1'b1;
            cnt = 0;
            while (!ready && cnt < 100) begin tick(); cnt++; end
            pll_locked = 1'b0;
            cnt = 0;
            while (!sys_reset && cnt < 20) begin tick(); cnt++; end
            if (lock_loss_count !== 8'((n < 255) ? n : 255)) begin
                $display("[TB] FAIL loss_count_%0d: got %0d expected %0d", n, lock_loss_count, (n < 255) ? n : 255);
                break;
            end else passed++;
            total++;
        end
    endtask

    task automatic test_relock_in_run();
        int cnt;
        do_reset();
        pll_locked = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin tick(); cnt++; end
        pll_locked = 1'b0;
        repeat (3) tick();
        if (ready !== 1'b1) $display("[TB] FAIL still_run_before_relock: got %0d expected %0d", ready, 1);
        else passed++;
        total++;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        if ({state_dbg, pll_rst, ready, lock_loss_count} !== {3'd0, 1'b1, 1'b0, 8'd0})
            $display("[TB] FAIL relock_vs_loss: got %b expected %b", {state_dbg, pll_rst, ready, lock_loss_count}, {3'd0, 1'b1, 1'b0, 8'd0});
        else passed++;
        total++;
    endtask

    task automatic test_rst_mid_wait();
        int cnt;
        logic [14:0] got;
        do_reset();
        cnt = 0;
        while (pll_rst && cnt < 50) begin tick(); cnt++; end
        repeat (10) tick();
        rst = 1'b1;
        model_reset();
        #1 got = {pll_rst, sys_reset, ready, fail, state_dbg, lock_loss_count};
        if (got !== 15'h6000) $display("[TB] FAIL async_reset: got %h expected %h", got, 15'h6000);
        else passed++;
        total++;
        tick();
        rst = 1'b0;
        cnt = 0;
        do begin tick(); cnt++; end while (pll_rst && cnt < 50);
        if (cnt !== RST_CYCLES) $display("[TB] FAIL post_reset_hold: got %0d expected %0d", cnt, RST_CYCLES);
        else passed++;
        total++;
        cnt = 0;
        while (!fail && cnt < 200) begin tick(); cnt++; end
        if (cnt !== LOCK_TIMEOUT + 2 * (RST_CYCLES + LOCK_TIMEOUT))
            $display("[TB] FAIL retries_restart: got %0d expected %0d", cnt, LOCK_TIMEOUT + 2 * (RST_CYCLES + LOCK_TIMEOUT));
        else passed++;
        total++;
    endtask

    task automatic test_random();
        logic [14:0] got, exp;
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(29, 0) == 0) pll_locked = ~pll_locked;
            relock_req = ($urandom_range(199, 0) == 0);
            tick();
            got = {pll_rst, sys_reset, ready, fail, state_dbg, lock_loss_count};
            exp = model_outputs();
            if (got !== exp) begin
                errs++;
                if (errs <= 5) $display("[TB] FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
            end else passed++;
            total++;
        end
        relock_req = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_sequence();
        test_fail_retry();
        test_stable_glitch();
        test_run_loss();
        test_relock_in_run();
        test_rst_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
